obi_mem_responder: RTL

//  Parametrised synthesizable memory slave for one core-side req/gnt/rvalid bus.

---
 rtl/obi_mem_pkg.sv | 23 ++
 rtl/obi_mem_responder_if.sv | 31 +++
 rtl/obi_resp_pipe.sv | 35 +++
 rtl/obi_mem_responder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/obi_mem_pkg.sv
// obi_mem_pkg
//   Shared definitions for the OBI memory responder:
//     ERR_PATTERN - read data returned for an out-of-range read
//     resp_t      - one response slot {valid, err, rdata} for the default 32-bit bus
//     idx_of()    - byte address to word index (drops addr[1:0])
package obi_mem_pkg;

  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;
  localparam int unsigned RESP_DW     = 32;

  typedef struct packed {
    logic               valid;
    logic               err;
    logic [RESP_DW-1:0] rdata;
  } resp_t;

  // Word index of a byte address. The caller truncates the result to its
  // own index width; sub-word address bits are ignored.
  function automatic logic [63:0] idx_of(input logic [63:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/obi_mem_responder_if.sv
// obi_mem_responder_if
//   Core-side req/gnt/rvalid bus.
//   master : drives req_i, addr_i, we_i, be_i, wdata_i; receives gnt_o, rvalid_o, rdata_o, err_o
//   slave  : the memory responder side (mirror of master)
//   Signal names keep the responder's port names so waveforms match the block's port list.
interface obi_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    req_i;
  logic                    gnt_o;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic                    we_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic                    rvalid_o;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic                    err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

endinterface

// File: rtl/obi_resp_pipe.sv
// obi_resp_pipe
//   Fixed-latency delay line for response slots. A slot entering on in_i
//   appears on out_o LAT clock edges later. Asynchronous active-low reset
//   empties every stage, so responses in flight at reset are lost.
//   Ports:
//     clk_i  in   clock
//     rst_ni in   async active-low reset
//     in_i   in   response slot captured this cycle (all-zero when idle)
//     out_o  out  oldest slot
module obi_resp_pipe
  import obi_mem_pkg::*;
#(
  parameter int unsigned LAT    = 2,
  parameter type         RESP_T = resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  RESP_T in_i,
  output RESP_T out_o
);

  RESP_T stage_q [LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(LAT); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < int'(LAT); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_o = stage_q[LAT-1];

endmodule

// File: rtl/obi_mem_responder.sv
// obi_mem_responder
//   Word-addressed memory slave for one core req/gnt/rvalid port.
//   Accepts on req && gnt, performs the memory access in the accept cycle,
//   and answers RVALID_LAT cycles later in accept order. Out-of-range
//   accesses answer with err set (reads return ERR_PATTERN, writes are dropped).
//   A preload port writes full words and takes priority over the bus.
//   Ports:
//     clk_i, rst_ni   clock, async active-low reset
//     bus             obi_mem_responder_if.slave (req/gnt/addr/we/be/wdata/rvalid/rdata/err)
//     pre_we_i        preload strobe; blocks the bus grant for that cycle
//     pre_addr_i      preload byte address
//     pre_wdata_i     preload word
//     outstanding_o   granted-but-unanswered transaction count
//   Build option: define OBI_MEM_STALL_EN to add LFSR-driven pseudo-random
//   grant stalls (16-bit LFSR, seed 16'hACE1, stall when lfsr[1:0]==0).
module obi_mem_responder
  import obi_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned RVALID_LAT      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  obi_mem_responder_if.slave                     bus,
  input  logic                                   pre_we_i,
  input  logic [ADDR_WIDTH-1:0]                  pre_addr_i,
  input  logic [DATA_WIDTH-1:0]                  pre_wdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int unsigned OSW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IDXW       = $clog2(DEPTH_WORDS);
  localparam int unsigned NBYTES     = DATA_WIDTH / 8;
  localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd4;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } resp_w_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic            accept;
  logic            retire;
  logic            slot_free;
  logic            stall;
  logic            in_range;
  logic            pre_in_range;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] pre_idx;
  logic [OSW-1:0]  cnt_q;
  logic [OSW-1:0]  cnt_d;
  resp_w_t         rsp_in;
  resp_w_t         rsp_out;

`ifdef OBI_MEM_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16/14/13/11; advances every cycle regardless of traffic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 16'hACE1;
    else         lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign in_range     = 64'(bus.addr_i) < BYTE_LIMIT;
  assign pre_in_range = 64'(pre_addr_i) < BYTE_LIMIT;
  assign idx          = IDXW'(idx_of(64'(bus.addr_i)));
  assign pre_idx      = IDXW'(idx_of(64'(pre_addr_i)));

  // A response leaving the pipe this cycle frees its slot in the same cycle,
  // which is what lets MAX_OUTSTANDING==RVALID_LAT sustain one accept per cycle.
  assign retire    = rsp_out.valid;
  assign slot_free = (32'(cnt_q) < MAX_OUTSTANDING) || retire;

  // rst_ni in the grant term keeps gnt_o low throughout reset even with req_i high.
  assign bus.gnt_o = rst_ni && bus.req_i && !pre_we_i && slot_free && !stall;
  assign accept    = bus.req_i && bus.gnt_o;

  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = accept;
    rsp_in.err   = accept && !in_range;
    if (accept && !bus.we_i) begin
      rsp_in.rdata = in_range ? mem[idx] : DATA_WIDTH'(ERR_PATTERN);
    end
  end

  // Memory contents survive reset; the read above sees the pre-write word.
  always_ff @(posedge clk_i) begin
    if (pre_we_i) begin
      if (pre_in_range) mem[pre_idx] <= pre_wdata_i;
    end else if (accept && bus.we_i && in_range) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (bus.be_i[b]) mem[idx][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
      end
    end
  end

  assign cnt_d = cnt_q + OSW'(accept) - OSW'(retire);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  obi_resp_pipe #(
    .LAT    (RVALID_LAT),
    .RESP_T (resp_w_t)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (rsp_in),
    .out_o  (rsp_out)
  );

  assign bus.rvalid_o  = rsp_out.valid;
  assign bus.rdata_o   = rsp_out.rdata;
  assign bus.err_o     = rsp_out.err;
  assign outstanding_o = cnt_q;

endmodule
